cache_controller: RTL and testbench

//  2-way set-associative, write-through, no-write-allocate data cache between MEM stage and 64-bit SRAM controller.

---
 rtl/cache_pkg.sv | 33 +++
 rtl/cache_controller_if.sv | 27 ++
 rtl/cache_way_array.sv | 35 +++
 rtl/cache_controller.sv | 155 +++++++++++++++
 tb/tb_cache_controller.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types, address field positions and line helpers for the data cache
package cache_pkg;

  localparam int SETS      = 64;
  localparam int INDEX_W   = $clog2(SETS);
  localparam int TAG_W     = 11;
  localparam int STAT_W    = 16;
  localparam int WORD_BIT  = 2;
  localparam int INDEX_LSB = 3;
  localparam int TAG_LSB   = 9;

  typedef enum logic [1:0] {
    IDLE,
    MISS,
    WRITE
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [63:0]      data;
  } line_t;

  function automatic logic [31:0] line_word(input logic [63:0] line, input logic sel);
    return sel ? line[63:32] : line[31:0];
  endfunction

  function automatic logic [63:0] merge_word(input logic [63:0] line, input logic sel,
                                             input logic [31:0] word);
    return sel ? {word, line[31:0]} : {line[63:32], word};
  endfunction

endpackage

// File: rtl/cache_controller_if.sv
// rtl/cache_controller_if.sv - MEM-stage request/response and SRAM-controller bus of the data cache
interface cache_controller_if;

  logic [31:0] address;
  logic [31:0] wdata;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic        sram_read;
  logic        sram_write;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  modport slave (
    input  address, wdata, MEM_R_EN, MEM_W_EN, sram_rdata, sram_ready,
    output rdata, ready, sram_address, sram_wdata, sram_read, sram_write
  );

  modport master (
    output address, wdata, MEM_R_EN, MEM_W_EN, sram_rdata, sram_ready,
    input  rdata, ready, sram_address, sram_wdata, sram_read, sram_write
  );

endinterface

// File: rtl/cache_way_array.sv
// rtl/cache_way_array.sv - one way of tag/valid/data storage: async read, sync write, valid cleared by reset
module cache_way_array
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] index,
  input  logic               wr_en,
  input  line_t              wr_line,
  output line_t              rd_line
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [63:0]      data_q [SETS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[index] <= wr_line.valid;
    end
  end

  // Tag/data need no reset: they are only observed through valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[index]  <= wr_line.tag;
      data_q[index] <= wr_line.data;
    end
  end

  assign rd_line = '{valid: valid_q[index], tag: tag_q[index], data: data_q[index]};

endmodule

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - 2-way write-through, no-write-allocate data cache; CACHE_STATS_EN adds hit/miss counters
module cache_controller
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
`ifdef CACHE_STATS_EN
  output logic [STAT_W-1:0] hit_count,
  output logic [STAT_W-1:0] miss_count,
`endif
  cache_controller_if.slave bus
);

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   addr_tag;
  logic               word_sel;
  line_t              line0, line1, hit_line, wr_line;
  logic               wr_en0, wr_en1;
  logic               hit0, hit1, hit, hit_way, victim;
  state_e             state_q, state_d;
  logic [SETS-1:0]    lru_q, lru_d;

  assign idx      = bus.address[INDEX_LSB +: INDEX_W];
  assign addr_tag = bus.address[TAG_LSB +: TAG_W];
  assign word_sel = bus.address[WORD_BIT];

  assign bus.sram_address = bus.address;
  assign bus.sram_wdata   = bus.wdata;

  cache_way_array u_way0 (
    .clk     (clk),
    .reset   (reset),
    .index   (idx),
    .wr_en   (wr_en0),
    .wr_line (wr_line),
    .rd_line (line0)
  );

  cache_way_array u_way1 (
    .clk     (clk),
    .reset   (reset),
    .index   (idx),
    .wr_en   (wr_en1),
    .wr_line (wr_line),
    .rd_line (line1)
  );

  assign hit0     = line0.valid && (line0.tag == addr_tag);
  assign hit1     = line1.valid && (line1.tag == addr_tag);
  assign hit      = hit0 || hit1;
  assign hit_way  = hit1;
  assign hit_line = hit_way ? line1 : line0;
  // Fill an empty way before displacing anything; lru only matters once both are valid.
  assign victim   = !line0.valid ? 1'b0 : (!line1.valid ? 1'b1 : lru_q[idx]);

  always_comb begin
    state_d        = state_q;
    lru_d          = lru_q;
    wr_en0         = 1'b0;
    wr_en1         = 1'b0;
    wr_line        = '0;
    bus.ready      = 1'b1;
    bus.rdata      = '0;
    bus.sram_read  = 1'b0;
    bus.sram_write = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (bus.MEM_W_EN) begin
            state_d   = WRITE;
            bus.ready = 1'b0;
          end else if (bus.MEM_R_EN) begin
            if (hit) begin
              bus.rdata  = line_word(hit_line.data, word_sel);
              lru_d[idx] = ~hit_way;
            end else begin
              state_d   = MISS;
              bus.ready = 1'b0;
            end
          end
        end
        MISS: begin
          bus.sram_read = 1'b1;
          bus.ready     = bus.sram_ready;
          if (bus.sram_ready) begin
            bus.rdata  = line_word(bus.sram_rdata, word_sel);
            wr_line    = '{valid: 1'b1, tag: addr_tag, data: bus.sram_rdata};
            wr_en0     = ~victim;
            wr_en1     = victim;
            lru_d[idx] = ~victim;
            state_d    = IDLE;
          end
        end
        WRITE: begin
          bus.sram_write = 1'b1;
          bus.ready      = bus.sram_ready;
          if (bus.sram_ready) begin
            state_d = IDLE;
            if (hit) begin
              wr_line    = '{valid: 1'b1, tag: addr_tag,
                             data: merge_word(hit_line.data, word_sel, bus.wdata)};
              wr_en0     = ~hit_way;
              wr_en1     = hit_way;
              lru_d[idx] = ~hit_way;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lru_q   <= '0;
    end else begin
      state_q <= state_d;
      lru_q   <= lru_d;
    end
  end

`ifdef CACHE_STATS_EN
  logic              rd_hit, rd_miss;
  logic [STAT_W-1:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

  assign rd_hit  = (state_q == IDLE) && !bus.MEM_W_EN && bus.MEM_R_EN && hit;
  assign rd_miss = (state_q == MISS) && bus.sram_ready;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (rd_hit && (hit_count_q != '1)) begin
      hit_count_d = hit_count_q + STAT_W'(1);
    end
    if (rd_miss && (miss_count_q != '1)) begin
      miss_count_d = miss_count_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - scoreboard bench: LRU set model plus SRAM memory model, directed and random traffic
module tb_cache_controller;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_controller_if bus();

`ifdef CACHE_STATS_EN
  logic [STAT_W-1:0] hit_count, miss_count;
`endif

  cache_controller dut (
    .clk        (clk),
    .reset      (reset),
`ifdef CACHE_STATS_EN
    .hit_count  (hit_count),
    .miss_count (miss_count),
`endif
    .bus        (bus)
  );

  typedef struct {
    bit          is_wr;
    bit          hit;
    logic [31:0] data;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   hold_resp = 1'b0;

  logic [63:0] mem [int];
  int          cnt [64];
  logic [10:0] mru [64];
  logic [10:0] oth [64];
  int          m_hits, m_misses;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  function automatic logic [63:0] mem_get(input logic [31:0] a);
    int k;
    k = int'(a[19:3]);
    if (!mem.exists(k)) mem[k] = {$urandom, $urandom};
    return mem[k];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) cnt[i] = 0;
    m_hits   = 0;
    m_misses = 0;
  endfunction

  // Per set: mru = most recently touched tag, oth = the one that goes next.
  function automatic bit model_access(input logic [31:0] a, input bit is_wr);
    int          s;
    logic [10:0] t;
    bit          h;
    s = int'(a[8:3]);
    t = a[19:9];
    if (cnt[s] >= 1 && mru[s] == t) begin
      h = 1'b1;
    end else if (cnt[s] == 2 && oth[s] == t) begin
      h = 1'b1;
      oth[s] = mru[s];
      mru[s] = t;
    end else begin
      h = 1'b0;
      if (!is_wr) begin
        oth[s] = mru[s];
        mru[s] = t;
        if (cnt[s] < 2) cnt[s]++;
      end
    end
    if (!is_wr) begin
      if (h) m_hits++;
      else m_misses++;
    end
    return h;
  endfunction

  task automatic issue(input logic [31:0] a, input bit is_wr, input logic [31:0] wd);
    exp_t e;
    bit   ok;
    logic [63:0] line;
    line    = mem_get(a);
    e.is_wr = is_wr;
    e.addr  = a;
    e.hit   = model_access(a, is_wr);
    e.data  = a[2] ? line[63:32] : line[31:0];
    exp_q.push_back(e);
    bus.address  = a;
    bus.wdata    = wd;
    bus.MEM_W_EN = is_wr;
    bus.MEM_R_EN = !is_wr;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.MEM_W_EN = 1'b0;
    bus.MEM_R_EN = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL timeout: ready never rose for addr %h (wanted within 40 cycles)", a);
      finish_run();
    end
  endtask

  // SRAM controller: random latency, single-cycle sram_ready, line data from the memory model.
  initial begin
    int d;
    logic [63:0] w;
    bus.sram_ready = 1'b0;
    bus.sram_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.sram_ready = 1'b0;
      if (!reset && (bus.sram_read || bus.sram_write)) begin
        d = $urandom_range(0, 3);
        while (hold_resp || d > 0) begin
          @(posedge clk);
          #2;
          d--;
        end
        if (!reset && (bus.sram_read || bus.sram_write)) begin
          check("sram_address", bus.sram_address, bus.address);
          if (bus.sram_write) begin
            check("sram_wdata", bus.sram_wdata, bus.wdata);
            w = mem_get(bus.address);
            if (bus.address[2]) w[63:32] = bus.wdata;
            else w[31:0] = bus.wdata;
            mem[int'(bus.address[19:3])] = w;
          end else begin
            bus.sram_rdata = mem_get(bus.address);
          end
          bus.sram_ready = 1'b1;
        end
      end
    end
  end

  // Monitor: pops one expectation per completed request and checks data, latency and SRAM traffic.
  initial begin
    int   cyc;
    bit   sr, sw;
    exp_t e;
    cyc = 0;
    sr  = 1'b0;
    sw  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cyc = 0;
        sr  = 1'b0;
        sw  = 1'b0;
      end else if (bus.MEM_R_EN || bus.MEM_W_EN) begin
        cyc++;
        sr = sr | bus.sram_read;
        sw = sw | bus.sram_write;
        if (bus.ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_completion: addr %h with empty scoreboard", bus.address);
          end else begin
            e = exp_q.pop_front();
            if (e.is_wr) begin
              check("wr_sram_write", 64'(sw), 64'(1));
              check("wr_no_sram_read", 64'(sr), 64'(0));
              check("wr_latency_gt1", 64'(cyc > 1), 64'(1));
            end else begin
              check("rd_data", 64'(bus.rdata), 64'(e.data));
              check("rd_single_cycle_hit", 64'(cyc == 1), 64'(e.hit));
              check("rd_sram_read", 64'(sr), 64'(!e.hit));
            end
          end
          cyc = 0;
          sr  = 1'b0;
          sw  = 1'b0;
        end
      end
    end
  end

  initial begin
    #1000000;
    total++;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_run();
  end

  initial begin
    logic [31:0] a;
    int          gap;
    reset        = 1'b1;
    bus.address  = '0;
    bus.wdata    = '0;
    bus.MEM_R_EN = 1'b0;
    bus.MEM_W_EN = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(bus.ready), 64'(1));
    check("rst_sram_read", 64'(bus.sram_read), 64'(0));
    check("rst_sram_write", 64'(bus.sram_write), 64'(0));
    check("rst_rdata", 64'(bus.rdata), 64'(0));
`ifdef CACHE_STATS_EN
    check("rst_hit_count", 64'(hit_count), 64'(0));
    check("rst_miss_count", 64'(miss_count), 64'(0));
`endif
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle_ready", 64'(bus.ready), 64'(1));

    issue(32'h0000_0410, 1'b0, '0);
    issue(32'h0000_0410, 1'b0, '0);
    issue(32'h0000_0414, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      int tg;
      tg = (i == 3) ? 1 : ((i == 4) ? 3 : i + 1);
      issue((32'(tg) << 9) | (32'd5 << 3), 1'b0, '0);
    end
    issue(32'h0000_0410, 1'b1, 32'hDEAD_BEEF);
    issue(32'h0000_0410, 1'b0, '0);
    check("stored_word", 64'(mem[int'(32'h410 >> 3)] & 64'hFFFF_FFFF), 64'h0000_0000_DEAD_BEEF);
    issue(32'h0000_2000, 1'b1, 32'h1234_5678);
    issue(32'h0000_2000, 1'b0, '0);
`ifdef CACHE_STATS_EN
    check("hit_count", 64'(hit_count), 64'(m_hits));
    check("miss_count", 64'(miss_count), 64'(m_misses));
`endif

    hold_resp    = 1'b1;
    bus.address  = 32'h0000_7A10;
    bus.MEM_R_EN = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
        @(negedge clk);
        seen = bus.sram_read;
      end
      check("abort_miss_started", 64'(seen), 64'(1));
    end
    #1;
    reset = 1'b1;
    #1;
    check("abort_sram_read", 64'(bus.sram_read), 64'(0));
    check("abort_ready", 64'(bus.ready), 64'(1));
    check("abort_rdata", 64'(bus.rdata), 64'(0));
    @(posedge clk);
    #1;
    bus.MEM_R_EN = 1'b0;
    hold_resp    = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
    issue(32'h0000_7A10, 1'b0, '0);
    issue(32'h0000_0410, 1'b0, '0);

    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 9);
      a = {12'h000, 11'($urandom_range(0, 3)),
           (r < 4) ? 6'd5 : ((r < 8) ? 6'd9 : 6'($urandom_range(0, 63))),
           1'($urandom), 2'b00};
      issue(a, ($urandom_range(0, 3) == 0), $urandom);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
`ifdef CACHE_STATS_EN
    check("final_hit_count", 64'(hit_count), 64'(m_hits));
    check("final_miss_count", 64'(miss_count), 64'(m_misses));
`endif
    finish_run();
  end

endmodule
